sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite/tile ROM between N pixel-layer requesters: background road, player car, obstacle cars, score overlay.
- Sits between the per-layer renderers and the ROM. The layers are driven by the pixel_x/pixel_y/video_on timing generator.
- Round-robin arbitration with a registered grant/address stage and a fixed-latency read-return pipeline.
- Each read result is returned tagged to the requester that issued it.

Parameters:
- N, 4, number of requesters (2..8).
- AW, 14, ROM address width.
- DW, 12, ROM data width (4:4:4 RGB).
- ROM_LAT, 1, ROM read latency in cycles from rom_en to rom_data valid (1..3).

Ports:
- clk  in  1  pixel clock.
- clr_n  in  1  synchronous active-low reset.
- req  in  N  per-requester read request; held with addr until the matching gnt bit is seen.
- addr  in  N*AW  flattened request addresses; requester i uses bits [i*AW +: AW].
- video_on  in  1  active-display flag from the timing generator; used only by the optional feature.
- gnt  out  N  one-hot, 1-cycle acceptance pulse.
- rom_en  out  1  ROM read enable.
- rom_addr  out  AW  ROM address.
- rom_data  in  DW  ROM read data.
- rd_valid  out  N  one-hot, 1-cycle return strobe.
- rd_data  out  DW  returned ROM data, registered.

Behaviour:
- Reset (clr_n low at posedge clk), synchronous:
  - gnt=0, rom_en=0, rom_addr=0, rd_valid=0, rd_data=0.
  - RR pointer=N-1, so requester 0 has first priority.
  - Tag pipeline cleared; in-flight reads are dropped and produce no rd_valid.
  - Reset mid-transfer is legal; requesters re-request afterwards.
- Arbitration, cycle T:
  - Eligible set E = req & ~gnt. The requester currently pulsed gnt is masked, so a held req is never double-granted.
  - If E is nonzero, the winner is the first set bit searching upward from pointer+1, modulo N.
- Issue, cycle T+1:
  - gnt[winner]=1, rom_en=1, rom_addr = addr[winner] as sampled at T.
  - Pointer <= winner.
  - If E was zero: gnt=0, rom_en=0, rom_addr holds its previous value.
- Throughput: at most one grant per cycle; back-to-back grants to different requesters are allowed.
- A requester that keeps req high in the cycle after its gnt pulse is treated as a new request. Its earliest next grant is T+3, and that only if no other requester is eligible.
- Return path:
  - The winner id enters a ROM_LAT-deep shift register alongside rom_en.
  - rom_data is captured at T+1+ROM_LAT.
  - rd_valid[id]=1 and rd_data=rom_data at T+2+ROM_LAT. Fixed latency from gnt to rd_valid is ROM_LAT+1.
  - rd_data holds its value when rd_valid=0.
- Ordering: returns are in grant order; there is no reordering or backpressure. Requesters must accept rd_valid unconditionally.
- Fairness: with all N requesting continuously, each is granted exactly once per N cycles.
- Requester protocol violations are not checked: dropping req before gnt is a withdrawn request; changing addr before gnt uses whatever addr is present at the arbitration cycle.

Optional Feature:
- Macro SPRITE_ROM_DISPLAY_PRIO_EN.
- Defined: while video_on=1 and requester 0 is eligible, requester 0 wins regardless of the pointer.
  - Such priority grants do not update the pointer.
  - With video_on=0, plain round-robin applies.
- Undefined: video_on is ignored (port kept, unused) and pure round-robin always applies.

Decomposition:
- Package sprite_rom_pkg holds:
  - Default constants N_REQ=4, ROM_AW=14, ROM_DW=12, ROM_LAT_DEF=1.
  - Typedef req_id_t, a $clog2(N) bits wide requester index.
  - Function onehot_from_id.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: eligible vector, pointer.
  - Outputs: found flag, winner id.
  - Instantiated once; verified standalone.

Test Plan:
1. Reset and idle: clr_n low 3 cycles mid-read, then req=0 -> gnt, rom_en and rd_valid stay 0; no return from the dropped read.
2. Single request: req=4'b0100, addr[2]=0x1A5, ROM model returns addr^0xFFF, ROM_LAT=1 -> gnt=4'b0100 at T+1 with rom_addr=0x1A5; rd_valid=4'b0100 and rd_data=0xE5A at T+3.
3. Full contention: req=4'b1111 held, each requester dropping req one cycle after its gnt and re-raising -> grant order 0,1,2,3,0,...; each requester granted once per 4 grants; never two consecutive grants to the same requester.
4. Held req after gnt: requester 1 alone holds req=1 continuously -> gnt[1] pulses every other cycle, never in consecutive cycles.
5. Latency sweep: ROM_LAT=1,2,3 with back-to-back grants to 0,1,2 -> rd_valid order 0,1,2, each exactly ROM_LAT+1 cycles after its gnt, data matching.
6. With SPRITE_ROM_DISPLAY_PRIO_EN: pointer=0, req=4'b0011, video_on=1 -> requester 0 granted every eligible cycle; video_on=0 -> alternation 1,0 resumes.

Source files
------------

// File: rtl/sprite_rom_pkg.sv
// Shared constants, requester index type and one-hot helper for the sprite ROM arbiter.
package sprite_rom_pkg;

    localparam int N_REQ       = 4;
    localparam int ROM_AW      = 14;
    localparam int ROM_DW      = 12;
    localparam int ROM_LAT_DEF = 1;

    typedef logic [$clog2(N_REQ)-1:0] req_id_t;

    // Sized for the largest supported requester count (8); callers slice to N.
    function automatic logic [7:0] onehot_from_id(input logic [2:0] id);
        return 8'(1) << id;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible bit searching upward from ptr+1, modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   elig,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] win
);

    int idx;

    // Scan from the farthest candidate down so the nearest one after ptr is written last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (elig[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among N layers, with tagged fixed-latency returns.
// Build option SPRITE_ROM_DISPLAY_PRIO_EN: requester 0 wins whenever video_on is high.
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int N       = N_REQ,
    parameter int AW      = ROM_AW,
    parameter int DW      = ROM_DW,
    parameter int ROM_LAT = ROM_LAT_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [N-1:0]  req,
    input  logic [N*AW-1:0] addr,
    input  logic          video_on,
    output logic [N-1:0]  gnt,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [N-1:0]  rd_valid,
    output logic [DW-1:0] rd_data
);

    localparam int IDW = $clog2(N);

    logic [N-1:0]   elig_p0;
    logic           rr_found_p0;
    logic [IDW-1:0] rr_win_p0;
    logic           prio_p0;
    logic           found_p0;
    logic [IDW-1:0] win_p0;
    logic [7:0]     win_oh_p0;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_id_p1;
    logic           vld_p2 [ROM_LAT];
    logic [IDW-1:0] tag_id_p2 [ROM_LAT];
    logic [7:0]     ret_oh_p2;

    // Stage p0: arbitration; the requester currently pulsed gnt is masked out.
    assign elig_p0 = req & ~gnt;

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .elig  (elig_p0),
        .ptr   (ptr),
        .found (rr_found_p0),
        .win   (rr_win_p0)
    );

`ifdef SPRITE_ROM_DISPLAY_PRIO_EN
    assign prio_p0 = video_on & elig_p0[0];
`else
    logic unused_video_on;
    assign unused_video_on = video_on;
    assign prio_p0         = 1'b0;
`endif

    assign found_p0  = rr_found_p0 | prio_p0;
    assign win_p0    = prio_p0 ? '0 : rr_win_p0;
    assign win_oh_p0 = onehot_from_id(3'(win_p0));

    // Stage p1: registered grant and ROM address; priority grants leave the pointer alone.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            gnt       <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            gnt_id_p1 <= '0;
            ptr       <= IDW'(N - 1);
        end else begin
            gnt       <= found_p0 ? win_oh_p0[N-1:0] : '0;
            rom_en    <= found_p0;
            gnt_id_p1 <= win_p0;
            if (found_p0)
                rom_addr <= addr[win_p0*AW +: AW];
            if (found_p0 && !prio_p0)
                ptr <= win_p0;
        end
    end

    // Stage p2: tag pipeline tracking the ROM read latency.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int s = 0; s < ROM_LAT; s++)
                vld_p2[s] <= 1'b0;
        end else begin
            vld_p2[0] <= rom_en;
            for (int s = 1; s < ROM_LAT; s++)
                vld_p2[s] <= vld_p2[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_p2[0] <= gnt_id_p1;
        for (int s = 1; s < ROM_LAT; s++)
            tag_id_p2[s] <= tag_id_p2[s-1];
    end

    assign ret_oh_p2 = onehot_from_id(3'(tag_id_p2[ROM_LAT-1]));

    // Stage p3: tagged return register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rd_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_valid <= vld_p2[ROM_LAT-1] ? ret_oh_p2[N-1:0] : '0;
            if (vld_p2[ROM_LAT-1])
                rd_data <= rom_data;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter; three instances with ROM_LAT 1, 2 and 3 share stimulus.
module tb_sprite_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N*AW-1:0] addr = '0;
    logic          video_on = 1'b0;

    logic [N-1:0]  gnt1, gnt2, gnt3;
    logic          rom_en1, rom_en2, rom_en3;
    logic [AW-1:0] rom_addr1, rom_addr2, rom_addr3;
    logic [DW-1:0] rom_data1, rom_data2, rom_data3;
    logic [DW-1:0] d2a, d3a, d3b;
    logic [N-1:0]  rd_valid1, rd_valid2, rd_valid3;
    logic [DW-1:0] rd_data1, rd_data2, rd_data3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ROM model: data = low address bits ^ 0xFFF, delayed by each instance's latency.
    always @(posedge clk) begin
        rom_data1 <= rom_addr1[DW-1:0] ^ 12'hFFF;
        d2a       <= rom_addr2[DW-1:0] ^ 12'hFFF;
        rom_data2 <= d2a;
        d3a       <= rom_addr3[DW-1:0] ^ 12'hFFF;
        d3b       <= d3a;
        rom_data3 <= d3b;
    end

    sprite_rom_arbiter #(.N(N), .AW(AW), .DW(DW), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .req(req), .addr(addr), .video_on(video_on),
        .gnt(gnt1), .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1),
        .rd_valid(rd_valid1), .rd_data(rd_data1));

    sprite_rom_arbiter #(.N(N), .AW(AW), .DW(DW), .ROM_LAT(2)) u_dut2 (
        .clk(clk), .clr_n(clr_n), .req(req), .addr(addr), .video_on(video_on),
        .gnt(gnt2), .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .rd_valid(rd_valid2), .rd_data(rd_data2));

    sprite_rom_arbiter #(.N(N), .AW(AW), .DW(DW), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .clr_n(clr_n), .req(req), .addr(addr), .video_on(video_on),
        .gnt(gnt3), .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_data(rom_data3),
        .rd_valid(rd_valid3), .rd_data(rd_data3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        req   = '0;
        tick();
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        addr[0*AW +: AW] = 14'h055;
        req = 4'b0001;
        tick();
        n_chk++;
        if (gnt1 !== 4'b0001) begin
            n_fail++; $display("FAIL reset_pre_gnt got %b want 0001", gnt1);
        end
        req   = '0;
        clr_n = 1'b0;
        tick();
        n_chk++;
        if (gnt1 !== '0 || rom_en1 !== 1'b0 || rom_addr1 !== '0 || rd_valid1 !== '0 || rd_data1 !== '0) begin
            n_fail++;
            $display("FAIL reset_values gnt=%b en=%b addr=%h rv=%b rd=%h want all zero",
                     gnt1, rom_en1, rom_addr1, rd_valid1, rd_data1);
        end
        tick();
        tick();
        clr_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (gnt1 !== '0 || rom_en1 !== 1'b0 || rd_valid1 !== '0 || rd_valid2 !== '0 || rd_valid3 !== '0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d gnt=%b en=%b rv=%b/%b/%b want zeros",
                         c, gnt1, rom_en1, rd_valid1, rd_valid2, rd_valid3);
            end
        end
    endtask

    task automatic test_single();
        addr[2*AW +: AW] = 14'h1A5;
        req = 4'b0100;
        tick();
        n_chk++;
        if (gnt1 !== 4'b0100 || rom_en1 !== 1'b1 || rom_addr1 !== 14'h1A5) begin
            n_fail++;
            $display("FAIL single_issue gnt=%b en=%b addr=%h want 0100 1 1a5", gnt1, rom_en1, rom_addr1);
        end
        req = '0;
        tick();
        n_chk++;
        if (gnt1 !== '0 || rd_valid1 !== '0) begin
            n_fail++; $display("FAIL single_gap gnt=%b rv=%b want 0000 0000", gnt1, rd_valid1);
        end
        tick();
        n_chk++;
        if (rd_valid1 !== 4'b0100 || rd_data1 !== 12'hE5A) begin
            n_fail++; $display("FAIL single_return rv=%b rd=%h want 0100 e5a", rd_valid1, rd_data1);
        end
        tick();
        n_chk++;
        if (rd_valid1 !== '0 || rd_data1 !== 12'hE5A) begin
            n_fail++; $display("FAIL single_hold rv=%b rd=%h want 0000 e5a", rd_valid1, rd_data1);
        end
        tick();
        tick();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = 4'(1 << (i % 4));
            n_chk++;
            if (gnt1 !== exp) begin
                n_fail++; $display("FAIL contention i=%0d gnt=%b want %b", i, gnt1, exp);
            end
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_held();
        logic [N-1:0] exp;
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            n_chk++;
            if (gnt1 !== exp) begin
                n_fail++; $display("FAIL held_req i=%0d gnt=%b want %b", i, gnt1, exp);
            end
        end
        req = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_latency_sweep();
        logic [N-1:0]  exp, rv;
        logic [DW-1:0] rd, exp_d;
        int j;
        do_reset();
        for (int i = 0; i < 3; i++)
            addr[i*AW +: AW] = 14'(14'h100 + i * 14'h101);
        req = 4'b0111;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = (c <= 3) ? 4'(1 << (c - 1)) : 4'b0000;
            n_chk++;
            if (gnt1 !== exp || gnt2 !== exp || gnt3 !== exp) begin
                n_fail++; $display("FAIL sweep_gnt c=%0d gnt=%b/%b/%b want %b", c, gnt1, gnt2, gnt3, exp);
            end
            req = req & ~gnt1;
            for (int l = 1; l <= 3; l++) begin
                case (l)
                    1:       begin rv = rd_valid1; rd = rd_data1; end
                    2:       begin rv = rd_valid2; rd = rd_data2; end
                    default: begin rv = rd_valid3; rd = rd_data3; end
                endcase
                j   = c - 2 - l;
                exp = (j >= 0 && j <= 2) ? 4'(1 << j) : 4'b0000;
                n_chk++;
                if (rv !== exp) begin
                    n_fail++; $display("FAIL sweep_rv lat=%0d c=%0d rv=%b want %b", l, c, rv, exp);
                end
                if (j >= 0 && j <= 2) begin
                    exp_d = 12'(12'h100 + j * 12'h101) ^ 12'hFFF;
                    n_chk++;
                    if (rd !== exp_d) begin
                        n_fail++; $display("FAIL sweep_data lat=%0d id=%0d rd=%h want %h", l, j, rd, exp_d);
                    end
                end
            end
        end
        req = '0;
        tick();
    endtask

`ifdef SPRITE_ROM_DISPLAY_PRIO_EN
    task automatic test_display_prio();
        logic [N-1:0] exp;
        do_reset();
        video_on = 1'b0;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        video_on = 1'b1;
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            n_chk++;
            if (gnt1 !== exp) begin
                n_fail++; $display("FAIL prio_on i=%0d gnt=%b want %b", i, gnt1, exp);
            end
        end
        req = '0;
        tick();
        video_on = 1'b0;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        req = 4'b0011;
        tick();
        n_chk++;
        if (gnt1 !== 4'b0010) begin
            n_fail++; $display("FAIL prio_off_first gnt=%b want 0010", gnt1);
        end
        tick();
        n_chk++;
        if (gnt1 !== 4'b0001) begin
            n_fail++; $display("FAIL prio_off_second gnt=%b want 0001", gnt1);
        end
        req = '0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_held();
        test_latency_sweep();
`ifdef SPRITE_ROM_DISPLAY_PRIO_EN
        test_display_prio();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
